// File: rtl/io_port_timer_if.sv
// tiny32 ports-region bus: CPU-side strobes, address and data toward the peripheral.
interface io_port_timer_if #(
    parameter int REG_ADDR_BITS = 3
);
    logic                     sel;
    logic [REG_ADDR_BITS-1:0] address;
    logic                     nrd;
    logic [3:0]               nwr;
    logic [31:0]              wdata;
    logic [31:0]              rdata;

    modport master (output sel, address, nrd, nwr, wdata, input rdata);
    modport slave  (input sel, address, nrd, nwr, wdata, output rdata);
endinterface

// File: rtl/io_port_timer.sv
// Open-drain outputs, edge-interrupt inputs and reload timer on the tiny32 bus; rdata one clk after request.
// No backpressure: one commit per request rising edge. Optional input filter under IO_DEBOUNCE_EN.
module io_port_timer #(
    parameter int OUT_BITS      = 8,
    parameter int IN_BITS       = 8,
    parameter int TIMER_BITS    = 24,
    parameter int REG_ADDR_BITS = 3
`ifdef IO_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_BITS = 16
`endif
) (
    input  logic                clk,
    input  logic                reset,
    io_port_timer_if.slave      bus,
    output logic [OUT_BITS-1:0] out_pins,
    input  logic [IN_BITS-1:0]  in_pins,
    output logic [1:0]          irq,
    input  logic [1:0]          interrupt_ack
);
    localparam int FALL_W = (IN_BITS > 16) ? 16 : IN_BITS;
    localparam logic [REG_ADDR_BITS-1:0] A_OUT    = REG_ADDR_BITS'(0);
    localparam logic [REG_ADDR_BITS-1:0] A_IN     = REG_ADDR_BITS'(1);
    localparam logic [REG_ADDR_BITS-1:0] A_EDGE   = REG_ADDR_BITS'(2);
    localparam logic [REG_ADDR_BITS-1:0] A_STATUS = REG_ADDR_BITS'(3);
    localparam logic [REG_ADDR_BITS-1:0] A_RELOAD = REG_ADDR_BITS'(4);
    localparam logic [REG_ADDR_BITS-1:0] A_COUNT  = REG_ADDR_BITS'(5);
    localparam logic [REG_ADDR_BITS-1:0] A_CTRL   = REG_ADDR_BITS'(6);

    logic                  req, req_q, req_rise, wr_en, rd_en, ctrl_wr, tmr_zero;
    logic [31:0]           byte_mask, rd_word, wr_word, w1c_word;
    logic [OUT_BITS-1:0]   out_reg;
    logic [IN_BITS-1:0]    sync1, sync2, in_filt, hist, rise_en, fall_mask;
    logic [IN_BITS-1:0]    gpio_status, edge_set, status_clr;
    logic [FALL_W-1:0]     fall_en;
    logic [TIMER_BITS-1:0] reload, count;
    logic                  run, oneshot, timer_ie, gpio_ie, tpend;

    // Held strobes must not re-commit, so only the request's rising edge acts.
    assign req       = bus.sel & (~bus.nrd | (bus.nwr != 4'hF));
    assign req_rise  = req & ~req_q;
    assign wr_en     = req_rise & (bus.nwr != 4'hF);
    assign rd_en     = req_rise & ~bus.nrd;
    assign ctrl_wr   = wr_en & (bus.address == A_CTRL);
    assign byte_mask = {{8{~bus.nwr[3]}}, {8{~bus.nwr[2]}}, {8{~bus.nwr[1]}}, {8{~bus.nwr[0]}}};
    assign w1c_word  = bus.wdata & byte_mask;
    assign wr_word   = (rd_word & ~byte_mask) | w1c_word;

    always_comb begin
        rd_word = '0;
        case (bus.address)
            A_OUT:    rd_word = 32'(out_reg);
            A_IN:     rd_word = 32'(in_filt);
            A_EDGE:   rd_word = 32'(rise_en) | (32'(fall_en) << 16);
            A_STATUS: rd_word = 32'(gpio_status);
            A_RELOAD: rd_word = 32'(reload);
            A_COUNT:  rd_word = 32'(count);
            A_CTRL:   rd_word = {28'd0, gpio_ie, timer_ie, oneshot, run};
            default:  rd_word = '0;
        endcase
    end

    assign fall_mask  = IN_BITS'(fall_en);
    assign edge_set   = (in_filt & ~hist & rise_en) | (~in_filt & hist & fall_mask);
    assign status_clr = interrupt_ack[1] ? '1 :
                        (wr_en && bus.address == A_STATUS) ? w1c_word[IN_BITS-1:0] : '0;
    assign tmr_zero   = run & (count == '0);

    assign out_pins = out_reg;
    assign irq      = {gpio_ie & (|gpio_status), tpend & timer_ie};

`ifdef IO_DEBOUNCE_EN
    logic [DEBOUNCE_BITS-1:0] db_cnt [IN_BITS];

    // Filtered level moves only after 2^DEBOUNCE_BITS consecutive disagreeing clks.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_BITS; i++) begin
            if (reset || sync2[i] == in_filt[i]) begin
                db_cnt[i] <= '0;
                if (reset) in_filt[i] <= 1'b0;
            end else if (&db_cnt[i]) begin
                db_cnt[i]  <= '0;
                in_filt[i] <= sync2[i];
            end else begin
                db_cnt[i] <= db_cnt[i] + DEBOUNCE_BITS'(1);
            end
        end
    end
`else
    assign in_filt = sync2;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q       <= 1'b0;
            bus.rdata   <= '0;
            out_reg     <= '1;
            sync1       <= '0;
            sync2       <= '0;
            hist        <= '0;
            rise_en     <= '0;
            fall_en     <= '0;
            gpio_status <= '0;
            reload      <= '1;
            count       <= '0;
            run         <= 1'b0;
            oneshot     <= 1'b0;
            timer_ie    <= 1'b0;
            gpio_ie     <= 1'b0;
            tpend       <= 1'b0;
        end else begin
            req_q       <= req;
            sync1       <= in_pins;
            sync2       <= sync1;
            hist        <= in_filt;
            gpio_status <= (gpio_status & ~status_clr) | edge_set;
            tpend       <= (tpend & ~interrupt_ack[0]) | tmr_zero;
            if (rd_en) bus.rdata <= rd_word;

            if (wr_en) begin
                case (bus.address)
                    A_OUT:    out_reg <= wr_word[OUT_BITS-1:0];
                    A_EDGE: begin
                        rise_en <= wr_word[IN_BITS-1:0];
                        fall_en <= wr_word[16 +: FALL_W];
                    end
                    A_RELOAD: reload <= wr_word[TIMER_BITS-1:0];
                    default: ;
                endcase
            end

            // A CTRL write decides RUN outright, overriding the one-shot auto-stop.
            if (ctrl_wr) begin
                run      <= wr_word[0];
                oneshot  <= wr_word[1];
                timer_ie <= wr_word[2];
                gpio_ie  <= wr_word[3];
            end else if (tmr_zero && oneshot) begin
                run <= 1'b0;
            end

            if (ctrl_wr && wr_word[0] && !run)
                count <= reload;
            else if (run)
                count <= tmr_zero ? reload : count - TIMER_BITS'(1);
        end
    end
endmodule

// File: tb/tb_io_port_timer.sv
// Randomized bus/pin traffic against a spec-level model, plus directed literal checks.
module tb_io_port_timer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] out_pins;
    logic [7:0] in_pins = 8'h08;
    logic [1:0] irq;
    logic [1:0] ack = 2'b00;
    bit         cmp_on = 1'b0;
    int         checks = 0;
    int         errors = 0;

    io_port_timer_if #(.REG_ADDR_BITS(3)) bus();

    io_port_timer #(.OUT_BITS(8), .IN_BITS(8), .TIMER_BITS(24), .REG_ADDR_BITS(3)) dut (
        .clk(clk), .reset(reset), .bus(bus), .out_pins(out_pins),
        .in_pins(in_pins), .irq(irq), .interrupt_ack(ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: register file as the CPU sees it, plus the input sample history.
    logic [7:0]  m_out, m_status, m_rise, m_fall, m_s1, m_s2, m_hist;
    logic [23:0] m_reload, m_count;
    logic        m_run, m_one, m_tie, m_gie, m_tp, m_req_prev;
    logic [31:0] m_rdata;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {24'd0, m_out};
            3'd1: return {24'd0, m_s2};
            3'd2: return {8'd0, m_fall, 8'd0, m_rise};
            3'd3: return {24'd0, m_status};
            3'd4: return {8'd0, m_reload};
            3'd5: return {8'd0, m_count};
            3'd6: return {28'd0, m_gie, m_tie, m_one, m_run};
            default: return 32'd0;
        endcase
    endfunction

    initial begin : model
        logic        req, rise, wr, rd, zero, start;
        logic [31:0] bm, cur, merged, w1c;
        logic [7:0]  set, clr;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_out = 8'hFF; m_status = 0; m_rise = 0; m_fall = 0;
                m_s1 = 0; m_s2 = 0; m_hist = 0; m_reload = 24'hFFFFFF; m_count = 0;
                m_run = 0; m_one = 0; m_tie = 0; m_gie = 0; m_tp = 0; m_req_prev = 0; m_rdata = 0;
            end else begin
                req    = bus.sel && (!bus.nrd || bus.nwr != 4'hF);
                rise   = req && !m_req_prev;
                wr     = rise && bus.nwr != 4'hF;
                rd     = rise && !bus.nrd;
                bm     = {{8{!bus.nwr[3]}}, {8{!bus.nwr[2]}}, {8{!bus.nwr[1]}}, {8{!bus.nwr[0]}}};
                cur    = m_read(bus.address);
                w1c    = bus.wdata & bm;
                merged = (cur & ~bm) | w1c;
                set    = (m_s2 & ~m_hist & m_rise) | (~m_s2 & m_hist & m_fall);
                clr    = ack[1] ? 8'hFF : (wr && bus.address == 3'd3) ? w1c[7:0] : 8'h00;
                zero   = m_run && m_count == 0;
                start  = wr && bus.address == 3'd6 && merged[0] && !m_run;

                if (rd) m_rdata = cur;
                m_req_prev = req;
                m_hist = m_s2; m_s2 = m_s1; m_s1 = in_pins;
                m_status = (m_status & ~clr) | set;
                m_tp = (m_tp && !ack[0]) || zero;
                if (start)      m_count = m_reload;
                else if (m_run) m_count = zero ? m_reload : m_count - 24'd1;
                if (wr && bus.address == 3'd6) {m_gie, m_tie, m_one, m_run} = merged[3:0];
                else if (zero && m_one)        m_run = 1'b0;
                if (wr) begin
                    if (bus.address == 3'd0) m_out = merged[7:0];
                    if (bus.address == 3'd2) begin m_rise = merged[7:0]; m_fall = merged[23:16]; end
                    if (bus.address == 3'd4) m_reload = merged[23:0];
                end
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                chk("out_pins", {24'd0, out_pins}, {24'd0, m_out});
                chk("irq", {30'd0, irq}, {30'd0, m_gie && (|m_status), m_tp && m_tie});
                chk("rdata", bus.rdata, m_rdata);
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // Called and returning at 2 time units after a rising edge.
    task automatic bus_op(input logic [2:0] a, input logic rd_n, input logic [3:0] wn,
                          input logic [31:0] d, input int hold);
        bus.sel = 1'b1; bus.address = a; bus.nrd = rd_n; bus.nwr = wn; bus.wdata = d;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #2;
            bus.wdata = ~d;
        end
        bus.sel = 1'b0; bus.nrd = 1'b1; bus.nwr = 4'hF;
        @(posedge clk); #2;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_op(a, 1'b1, 4'h0, d, 1);
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        bus_op(a, 1'b0, 4'hF, 32'd0, 1);
        d = bus.rdata;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
    endtask

    initial begin : stim
        logic [31:0] v;
        int t_rise[$];
        int rises, first;
        bit prev, seen;
        bus.sel = 1'b0; bus.address = '0; bus.nrd = 1'b1; bus.nwr = 4'hF; bus.wdata = '0;
        tick(2);
        reset = 1'b0;
        cmp_on = 1'b1;
        chk("rst_out_pins", {24'd0, out_pins}, 32'hFF);
        chk("rst_irq", {30'd0, irq}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        rd(3'd5, v); chk("rst_count", v, 32'd0);
        rd(3'd4, v); chk("rst_reload", v, 32'h00FF_FFFF);

        // Held strobe with changing data: only the first cycle may commit.
        bus_op(3'd0, 1'b1, 4'b1110, 32'h5A, 5);
        chk("out_single_commit", {24'd0, out_pins}, 32'h5A);
        bus_op(3'd0, 1'b1, 4'b1101, 32'h0000_3C3C, 1);
        chk("out_wide_byte_ignored", {24'd0, out_pins}, 32'h5A);

        // Periodic timer: pending every RELOAD+1 clks.
        wr(3'd4, 32'd3);
        wr(3'd6, 32'h5);
        for (int i = 0; i < 40 && t_rise.size() < 3; i++) begin
            if (irq[0]) begin t_rise.push_back(i); ack = 2'b01; end
            tick(1);
            ack = 2'b00;
        end
        chk("periodic_rises", t_rise.size(), 3);
        if (t_rise.size() == 3) begin
            chk("periodic_gap1", t_rise[1] - t_rise[0], 4);
            chk("periodic_gap2", t_rise[2] - t_rise[1], 4);
        end
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (m_run && m_count == 0) seen = 1'b1; else tick(1);
        end
        chk("ack_window_found", {31'd0, seen}, 32'd1);
        ack = 2'b01;
        tick(1);
        ack = 2'b00;
        chk("ack_vs_set_irq0", {31'd0, irq[0]}, 32'd1);
        wr(3'd6, 32'h0);
        ack = 2'b01; tick(1); ack = 2'b00;

        // One-shot timer.
        wr(3'd4, 32'd5);
        wr(3'd6, 32'h7);
        rises = 0; first = -1; prev = irq[0];
        for (int i = 0; i < 12; i++) begin
            if (irq[0] && !prev) begin rises++; if (first < 0) first = i; end
            prev = irq[0];
            tick(1);
        end
        chk("oneshot_rises", rises, 1);
        chk("oneshot_latency", first, 5);
        ack = 2'b01; tick(1); ack = 2'b00;
        rd(3'd6, v); chk("oneshot_ctrl", v, 32'h6);
        rd(3'd5, v); chk("oneshot_count", v, 32'd5);

        // GPIO edges: rise on bit0, fall on bit3.
        wr(3'd3, 32'hFF);
        wr(3'd2, 32'h0008_0001);
        wr(3'd6, 32'h8);
        in_pins = 8'h01;
        tick(3);
        chk("gpio_irq1", {30'd0, irq}, 32'h2);
        rd(3'd3, v); chk("gpio_status", v, 32'h09);
        rd(3'd1, v); chk("gpio_in", v, 32'h01);
        wr(3'd3, 32'h01);
        rd(3'd3, v); chk("gpio_w1c", v, 32'h08);

        // Random traffic against the model.
        for (int n = 0; n < 450; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1; tick(1); reset = 1'b0;
            end
            in_pins = 8'($urandom);
            ack = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
            bus_op(3'($urandom), 1'($urandom), 4'($urandom),
                   $urandom_range(0, 1) ? 32'($urandom_range(0, 15)) : $urandom,
                   $urandom_range(1, 3));
            ack = 2'b00;
            if ($urandom_range(0, 2) == 0) tick($urandom_range(1, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
